// File: rtl/toysram_pkg.sv
// Shared constants, FSM state codes and the parity helper for the toysram 2R1W register file.
package toysram_pkg;

  localparam int unsigned DEF_WIDTH = 12;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned MAX_WIDTH = 64;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Even parity of a row; narrower rows are zero-extended, which leaves parity unchanged.
  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/toysram_rd_port.sv
// One read port: range check, write-first bypass, registered data/valid (and parity check).
// Parity check logic exists only when TOYSRAM_PARITY_EN is defined.
module toysram_rd_port
  import toysram_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] row_data,
`ifdef TOYSRAM_PARITY_EN
  input  logic             row_par,
  output logic             par_err,
`endif
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic             in_range_c;
  logic             hit_c;
  logic             take_c;
  logic [WIDTH-1:0] data_nxt_c;
`ifdef TOYSRAM_PARITY_EN
  logic             par_nxt_c;
`endif

  // Select the next read value: zero when out of range, write data on a same-row collision.
  always_comb begin
    in_range_c = ({1'b0, rd_addr} < DEPTH_W);
    hit_c      = wr_en && (wr_addr == rd_addr);
    take_c     = run && rd_en;
    data_nxt_c = '0;
    if (in_range_c) begin
      data_nxt_c = hit_c ? wr_data : row_data;
    end
`ifdef TOYSRAM_PARITY_EN
    par_nxt_c = in_range_c && !hit_c &&
                (even_parity(MAX_WIDTH'(row_data)) != row_par);
`endif
  end

  // Output registers; data holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
`ifdef TOYSRAM_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      rd_valid <= take_c;
      if (take_c) begin
        rd_data <= data_nxt_c;
      end
`ifdef TOYSRAM_PARITY_EN
      par_err  <= take_c && par_nxt_c;
`endif
    end
  end

endmodule

// File: rtl/toysram_rf_2r1w.sv
// Parametrised 2-read/1-write register-file subarray with post-reset init sweep.
// Optional per-row even parity is enabled by defining TOYSRAM_PARITY_EN.
module toysram_rf_2r1w
  import toysram_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEF_WIDTH,
  parameter int unsigned      DEPTH    = DEF_DEPTH,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int unsigned     AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd0_en,
  input  logic [AW-1:0]    rd0_addr,
  output logic [WIDTH-1:0] rd0_data,
  output logic             rd0_valid,
  input  logic             rd1_en,
  input  logic [AW-1:0]    rd1_addr,
  output logic [WIDTH-1:0] rd1_data,
  output logic             rd1_valid,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             init_busy
`ifdef TOYSRAM_PARITY_EN
  ,
  output logic             par_err0,
  output logic             par_err1
`endif
);

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [AW-1:0]    init_ptr;
  logic [AW-1:0]    init_ptr_nxt;
  logic             busy_nxt;
  logic             init_we_c;
  logic             run_c;
  logic             wr_ok_c;
  logic [WIDTH-1:0] row0_c;
  logic [WIDTH-1:0] row1_c;

  logic [WIDTH-1:0] mem [DEPTH];
`ifdef TOYSRAM_PARITY_EN
  logic [DEPTH-1:0] mem_par;
  logic             par0_c;
  logic             par1_c;
`endif

  // FSM state, sweep pointer and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      init_ptr  <= '0;
      init_busy <= 1'b1;
    end else begin
      state     <= state_nxt;
      init_ptr  <= init_ptr_nxt;
      init_busy <= busy_nxt;
    end
  end

  // Next state: sweep every row once, then run until the next reset.
  always_comb begin
    state_nxt    = state;
    init_ptr_nxt = init_ptr;
    busy_nxt     = init_busy;
    init_we_c    = 1'b0;
    case (state)
      ST_INIT: begin
        init_we_c    = 1'b1;
        init_ptr_nxt = init_ptr + AW'(1);
        if (init_ptr == LAST_ROW) begin
          state_nxt    = ST_RUN;
          init_ptr_nxt = '0;
          busy_nxt     = 1'b0;
        end
      end
      ST_RUN: begin
        busy_nxt = 1'b0;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Accepted writes and row fetches for both read ports.
  always_comb begin
    run_c   = (state == ST_RUN);
    wr_ok_c = wr_en && run_c && ({1'b0, wr_addr} < DEPTH_W);
    row0_c  = mem[rd0_addr];
    row1_c  = mem[rd1_addr];
`ifdef TOYSRAM_PARITY_EN
    par0_c  = mem_par[rd0_addr];
    par1_c  = mem_par[rd1_addr];
`endif
  end

  // Array storage: init sweep has the write port while busy; contents are never reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_we_c) begin
        mem[init_ptr]     <= INIT_VAL;
`ifdef TOYSRAM_PARITY_EN
        mem_par[init_ptr] <= even_parity(MAX_WIDTH'(INIT_VAL));
`endif
      end else if (wr_ok_c) begin
        mem[wr_addr]      <= wr_data;
`ifdef TOYSRAM_PARITY_EN
        mem_par[wr_addr]  <= even_parity(MAX_WIDTH'(wr_data));
`endif
      end
    end
  end

  toysram_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd0 (
    .clk      (clk),
    .rst      (rst),
    .run      (run_c),
    .rd_en    (rd0_en),
    .rd_addr  (rd0_addr),
    .row_data (row0_c),
`ifdef TOYSRAM_PARITY_EN
    .row_par  (par0_c),
    .par_err  (par_err0),
`endif
    .wr_en    (wr_ok_c),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data  (rd0_data),
    .rd_valid (rd0_valid)
  );

  toysram_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd1 (
    .clk      (clk),
    .rst      (rst),
    .run      (run_c),
    .rd_en    (rd1_en),
    .rd_addr  (rd1_addr),
    .row_data (row1_c),
`ifdef TOYSRAM_PARITY_EN
    .row_par  (par1_c),
    .par_err  (par_err1),
`endif
    .wr_en    (wr_ok_c),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data  (rd1_data),
    .rd_valid (rd1_valid)
  );

endmodule

// File: tb/tb_toysram_rf_2r1w.sv
// Bench for toysram_rf_2r1w: a 16-row and a 12-row instance share stimulus and are
// checked every cycle against an array-based reference model.
module tb_toysram_rf_2r1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd0_en, rd1_en, wr_en;
  logic [3:0]  rd0_addr, rd1_addr, wr_addr;
  logic [11:0] wr_data;

  logic [11:0] a_d0, a_d1, b_d0, b_d1;
  logic        a_v0, a_v1, b_v0, b_v1, a_busy, b_busy;
`ifdef TOYSRAM_PARITY_EN
  logic        a_p0, a_p1, b_p0, b_p1;
`endif

  toysram_rf_2r1w #(.WIDTH(12), .DEPTH(16)) d16 (
    .clk(clk), .rst(rst),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(a_d0), .rd0_valid(a_v0),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(a_d1), .rd1_valid(a_v1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_busy(a_busy)
`ifdef TOYSRAM_PARITY_EN
    , .par_err0(a_p0), .par_err1(a_p1)
`endif
  );

  toysram_rf_2r1w #(.WIDTH(12), .DEPTH(12)) d12 (
    .clk(clk), .rst(rst),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(b_d0), .rd0_valid(b_v0),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(b_d1), .rd1_valid(b_v1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_busy(b_busy)
`ifdef TOYSRAM_PARITY_EN
    , .par_err0(b_p0), .par_err1(b_p1)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state, index [dut][...] with dut 0 = 16 rows, dut 1 = 12 rows.
  int unsigned dep [2] = '{16, 12};
  int unsigned cnt [2];
  logic [11:0] mm  [2][16];
  logic [11:0] ed  [2][2];
  logic        ev  [2][2];
  logic        eb  [2];
`ifdef TOYSRAM_PARITY_EN
  logic        pbad[2][16];
  logic        ep  [2][2];
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the currently applied inputs.
  task automatic model_edge();
    logic        pe [2];
    logic [3:0]  pa [2];
    int unsigned a, wa;
    pe[0] = rd0_en; pe[1] = rd1_en;
    pa[0] = rd0_addr; pa[1] = rd1_addr;
    wa = 32'(wr_addr);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cnt[k] = 0;
        eb[k]  = 1'b1;
        for (int p = 0; p < 2; p++) begin
          ev[k][p] = 1'b0; ed[k][p] = '0;
`ifdef TOYSRAM_PARITY_EN
          ep[k][p] = 1'b0;
`endif
        end
      end else if (cnt[k] < dep[k]) begin
        mm[k][cnt[k]] = '0;
`ifdef TOYSRAM_PARITY_EN
        pbad[k][cnt[k]] = 1'b0;
`endif
        cnt[k]++;
        eb[k] = (cnt[k] < dep[k]);
        for (int p = 0; p < 2; p++) begin
          ev[k][p] = 1'b0;
`ifdef TOYSRAM_PARITY_EN
          ep[k][p] = 1'b0;
`endif
        end
      end else begin
        eb[k] = 1'b0;
        for (int p = 0; p < 2; p++) begin
          a = 32'(pa[p]);
          ev[k][p] = pe[p];
`ifdef TOYSRAM_PARITY_EN
          ep[k][p] = 1'b0;
`endif
          if (pe[p]) begin
            if (a >= dep[k])                 ed[k][p] = '0;
            else if (wr_en && wa == a)       ed[k][p] = wr_data;
            else begin
              ed[k][p] = mm[k][a];
`ifdef TOYSRAM_PARITY_EN
              ep[k][p] = pbad[k][a];
`endif
            end
          end
        end
        if (wr_en && wa < dep[k]) begin
          mm[k][wa] = wr_data;
`ifdef TOYSRAM_PARITY_EN
          pbad[k][wa] = 1'b0;
`endif
        end
      end
    end
  endtask

  task automatic check_all();
    logic [11:0] od [2][2];
    logic        ov [2][2];
    logic        ob [2];
    string       nm;
    od[0][0] = a_d0; od[0][1] = a_d1; od[1][0] = b_d0; od[1][1] = b_d1;
    ov[0][0] = a_v0; ov[0][1] = a_v1; ov[1][0] = b_v0; ov[1][1] = b_v1;
    ob[0] = a_busy; ob[1] = b_busy;
    for (int k = 0; k < 2; k++) begin
      nm = (k == 0) ? "d16" : "d12";
      chk({nm, "_busy"}, 32'(ob[k]), 32'(eb[k]));
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("%s_valid%0d", nm, p), 32'(ov[k][p]), 32'(ev[k][p]));
        chk($sformatf("%s_data%0d", nm, p), 32'(od[k][p]), 32'(ed[k][p]));
      end
    end
`ifdef TOYSRAM_PARITY_EN
    chk("d16_par0", 32'(a_p0), 32'(ep[0][0]));
    chk("d16_par1", 32'(a_p1), 32'(ep[0][1]));
    chk("d12_par0", 32'(b_p0), 32'(ep[1][0]));
    chk("d12_par1", 32'(b_p1), 32'(ep[1][1]));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic e0, input logic [3:0] a0, input logic e1, input logic [3:0] a1,
                       input logic we, input logic [3:0] wa, input logic [11:0] wd);
    rd0_en = e0; rd0_addr = a0; rd1_en = e1; rd1_addr = a1;
    wr_en = we; wr_addr = wa; wr_data = wd;
  endtask

  task automatic rand_drive();
    drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          12'($urandom_range(0, 4095)));
  endtask

  // Count sampled busy cycles from reset release until the 16-row sweep ends.
  task automatic busy_count(input bit randomize_req, output int n16, output int n12);
    n16 = 0; n12 = 0;
    for (int i = 0; i < 40; i++) begin
      if (!a_busy) break;
      n16++;
      if (b_busy) n12++;
      if (randomize_req) rand_drive();
      cycle();
    end
  endtask

  initial begin
    int n16, n12;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Reset and init sweep
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle();
    chk("reset_busy", 32'(a_busy), 32'd1);
    chk("reset_data0", 32'(a_d0), 32'd0);
    rst = 1'b0;
    busy_count(1'b0, n16, n12);
    chk("init_len16", 32'(n16), 32'd16);
    chk("init_len12", 32'(n12), 32'd12);

    // Every row reads back the init value
    for (int i = 0; i < 16; i++) begin
      drive(1, 4'(i), 1, 4'(15 - i), 0, 0, 0);
      cycle();
      chk("init_row_p0", 32'(a_d0), 32'd0);
      chk("init_row_v0", 32'(a_v0), 32'd1);
    end

    // Write then read latency
    drive(0, 0, 0, 0, 1, 4'd7, 12'hA5C); cycle();
    drive(1, 4'd7, 0, 0, 0, 0, 0);       cycle();
    chk("lat_data", 32'(a_d0), 32'hA5C);
    chk("lat_valid", 32'(a_v0), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);          cycle();
    chk("lat_valid_drop", 32'(a_v0), 32'd0);
    chk("lat_hold", 32'(a_d0), 32'hA5C);

    // Write-first bypass on both ports
    drive(0, 0, 0, 0, 1, 4'd3, 12'h111); cycle();
    drive(1, 4'd3, 1, 4'd3, 1, 4'd3, 12'h2F0); cycle();
    chk("byp_p0", 32'(a_d0), 32'h2F0);
    chk("byp_p1", 32'(a_d1), 32'h2F0);
    drive(1, 4'd3, 1, 4'd3, 0, 0, 0); cycle();
    chk("byp_after", 32'(a_d0), 32'h2F0);

    // 12-row instance: independent ports and out-of-range handling
    drive(0, 0, 0, 0, 1, 4'd0, 12'h123);  cycle();
    drive(0, 0, 0, 0, 1, 4'd11, 12'hBEE); cycle();
    drive(1, 4'd0, 1, 4'd11, 0, 0, 0);    cycle();
    chk("d12_row0", 32'(b_d0), 32'h123);
    chk("d12_row11", 32'(b_d1), 32'hBEE);
    drive(0, 0, 0, 0, 1, 4'd13, 12'hFFF); cycle();
    drive(1, 4'd13, 1, 4'd13, 0, 0, 0);   cycle();
    chk("d12_oor_data", 32'(b_d0), 32'd0);
    chk("d12_oor_valid", 32'(b_v0), 32'd1);
    chk("d16_row13", 32'(a_d0), 32'hFFF);
    for (int i = 0; i < 12; i++) begin
      drive(1, 4'(i), 0, 0, 0, 0, 0);
      cycle();
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_drive();
      cycle();
    end

    // Reset in the middle of a sweep restarts it
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; cycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_drive();
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; cycle();
    rst = 1'b0;
    busy_count(1'b1, n16, n12);
    chk("resweep_len16", 32'(n16), 32'd16);
    chk("resweep_len12", 32'(n12), 32'd12);
    for (int i = 0; i < 16; i++) begin
      drive(1, 4'(i), 0, 0, 0, 0, 0);
      cycle();
      chk("resweep_row", 32'(a_d0), 32'd0);
    end

`ifdef TOYSRAM_PARITY_EN
    // Corrupted stored parity is flagged; a bypassed read is not
    drive(0, 0, 0, 0, 1, 4'd2, 12'h001); cycle();
    d16.mem_par[2] = ~d16.mem_par[2];
    pbad[0][2] = 1'b1;
    drive(1, 4'd2, 0, 0, 0, 0, 0); cycle();
    chk("par_err", 32'(a_p0), 32'd1);
    chk("par_valid", 32'(a_v0), 32'd1);
    drive(1, 4'd2, 0, 0, 1, 4'd2, 12'h001); cycle();
    chk("par_bypass", 32'(a_p0), 32'd0);
`endif

    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
